// File: rtl/mult_div_seq.sv
// Iterative multiply/divide unit: shift-add multiply or restoring divide, one bit per clock.
// The 64-bit result lands in hi/lo, and lo is written back to the register bank for one cycle.
module mult_div_seq #(
    parameter int unsigned size = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [size-1:0] A,
    input  logic [size-1:0] B,
    input  logic [4:0]      dest_reg,
    output logic            busy,
    output logic            done,
    output logic            div0,
    output logic [size-1:0] hi,
    output logic [size-1:0] lo,
    output logic [4:0]      WriteReg,
    output logic [size-1:0] WriteData,
    output logic            RegWrite
);

    localparam int unsigned CW = $clog2(size);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, next_state;

    logic [CW-1:0]     count;
    logic [2*size:0]   acc;
    logic [size-1:0]   mcand;
    logic [size-1:0]   a_orig;
    logic              is_div, neg_res, neg_rem, dz;

    logic              accept;
    logic [size-1:0]   mag_a, mag_b;
    logic [size:0]     mul_sum;
    logic [size+1:0]   trial;
    logic [2*size:0]   acc_step;
    logic [2*size-1:0] prod_fix;
    logic [size-1:0]   quot_fix, rem_fix;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (count == CW'(size - 1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign RegWrite  = (state == DONE);
    assign WriteData = lo;

    // Multiply and divide share the accumulator: {carry/rem, multiplier/quotient}.
    always_comb begin
        mag_a   = (op[1] && A[size-1]) ? -A : A;
        mag_b   = (op[1] && B[size-1]) ? -B : B;
        mul_sum = {1'b0, acc[2*size-1:size]} + {1'b0, mcand};
        trial   = {1'b0, acc[2*size-1:size-1]} - {2'b00, mcand};
        if (is_div) begin
            if (!trial[size+1]) acc_step = {trial[size:0], acc[size-2:0], 1'b1};
            else                acc_step = {acc[2*size-1:0], 1'b0};
        end else begin
            if (acc[0]) acc_step = {1'b0, mul_sum, acc[size-1:1]};
            else        acc_step = acc >> 1;
        end
        prod_fix = neg_res ? -acc[2*size-1:0] : acc[2*size-1:0];
        quot_fix = neg_res ? -acc[size-1:0] : acc[size-1:0];
        rem_fix  = neg_rem ? -acc[2*size-1:size] : acc[2*size-1:size];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            acc      <= '0;
            mcand    <= '0;
            a_orig   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            WriteReg <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    count    <= '0;
                    acc      <= {{(size+1){1'b0}}, (op[0] ? mag_a : mag_b)};
                    mcand    <= op[0] ? mag_b : mag_a;
                    a_orig   <= A;
                    is_div   <= op[0];
                    neg_res  <= op[1] & (A[size-1] ^ B[size-1]);
                    neg_rem  <= op[1] & A[size-1];
                    dz       <= op[0] & (B == '0);
                    div0     <= 1'b0;
                    WriteReg <= dest_reg;
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (dz) begin
                        // Divide by zero reports the raw dividend, not the magnitude.
                        lo   <= '1;
                        hi   <= a_orig;
                        div0 <= 1'b1;
                    end else begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: expected results are queued when a request is driven
// and checked when the done pulse appears.
module tb_mult_div_seq;

    logic        clock, reset_n, start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic [4:0]  dest_reg;
    logic        busy, done, div0, RegWrite;
    logic [31:0] hi, lo, WriteData;
    logic [4:0]  WriteReg;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  wreg;
        logic        div0;
    } exp_t;

    exp_t sb[$];

    mult_div_seq #(.size(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
        .dest_reg(dest_reg), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic [4:0] d, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ediv0, input bit hold);
        exp_t e;
        int n;
        e.hi = ehi; e.lo = elo; e.wreg = d; e.div0 = ediv0;
        sb.push_back(e);
        @(negedge clock);
        A = a; B = b; op = o; dest_reg = d; start = 1'b1;
        @(posedge clock); #1;
        A = $urandom; B = $urandom; op = 2'($urandom); dest_reg = 5'($urandom);
        if (!hold) start = 1'b0;
        check("busy_after_accept", busy, 1);
        check("div0_cleared", div0, 0);
        n = 0;
        while (n < 40 && done !== 1'b1) begin
            @(posedge clock); #1;
            n++;
        end
        check("latency", n, 33);
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("WriteData", WriteData, e.lo);
        check("WriteReg", WriteReg, e.wreg);
        check("RegWrite", RegWrite, 1);
        check("busy_in_done", busy, 1);
        check("div0", div0, e.div0);
        @(posedge clock); #1;
        check("done_one_cycle", done, 0);
        check("RegWrite_one_cycle", RegWrite, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        int rw_seen;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; A = '0; B = '0; dest_reg = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_WriteReg", WriteReg, 0);
        check("rst_RegWrite", RegWrite, 0);
        @(negedge clock); reset_n = 1'b1;

        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 5'd8,  32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        do_op(32'hFFFFFFFB, 32'd3,        2'b10, 5'd9,  32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        do_op(32'd100,      32'd7,        2'b01, 5'd10, 32'd2,        32'd14,       1'b0, 1'b0);
        do_op(32'hFFFFFFF9, 32'd2,        2'b11, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        do_op(32'h80000000, 32'hFFFFFFFF, 2'b11, 5'd12, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        do_op(32'd12,       32'd0,        2'b01, 5'd13, 32'd12,       32'hFFFFFFFF, 1'b1, 1'b0);
        do_op(32'd6,        32'd5,        2'b00, 5'd0,  32'd0,        32'd30,       1'b0, 1'b0);
        do_op(32'hFFFFFFF4, 32'd0,        2'b11, 5'd14, 32'hFFFFFFF4, 32'hFFFFFFFF, 1'b1, 1'b0);
        // Held start: second request must be taken on the first IDLE cycle after DONE.
        do_op(32'h00010000, 32'h00010000, 2'b00, 5'd15, 32'd1,        32'd0,        1'b0, 1'b1);
        do_op(32'hFFFFFFFF, 32'd2,        2'b10, 5'd16, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);

        rw_seen = 0;
        @(negedge clock);
        A = 32'd7; B = 32'd9; op = 2'b00; dest_reg = 5'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clock); #1;
            if (RegWrite) rw_seen++;
        end
        reset_n = 1'b0;
        #1;
        check("midrun_busy", busy, 0);
        check("midrun_hi", hi, 0);
        check("midrun_lo", lo, 0);
        check("midrun_div0", div0, 0);
        @(negedge clock); reset_n = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            if (RegWrite) rw_seen++;
        end
        check("midrun_no_writeback", rw_seen, 0);
        check("midrun_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
